axi_addr_cdc_issuer: RTL and testbench

//  Read-domain consumer of the 4-deep, 49-bit address-channel async FIFO.

---
 rtl/axi_addr_cdc_issuer.sv | 96 +++++++++
 tb/tb_axi_addr_cdc_issuer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/axi_addr_cdc_issuer.sv
// Read-domain consumer of the address-channel async FIFO: pops packed AXI address
// beats into a registered AxVALID/AxREADY master port, bounded by an outstanding-burst credit.
module axi_addr_cdc_issuer #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_not_empty,
  input  logic [48:0]      fifo_r_data,
  output logic             fifo_rd_en,
  output logic [7:0]       a_id,
  output logic [31:0]      a_addr,
  output logic [3:0]       a_len,
  output logic [2:0]       a_size,
  output logic [1:0]       a_burst,
  output logic             a_valid,
  input  logic             a_ready,
  input  logic             cpl_valid,
  output logic [CNT_W-1:0] in_flight,
  output logic             burst_err
);

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } beat_t;

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);

  state_t state, state_nxt;
  beat_t  beat_q, beat_in;
  logic   can_take, credit, pop, cpl_eff;

  assign beat_in  = beat_t'(fifo_r_data);
  // can_take uses the registered state, so a_valid never sees a_ready combinationally.
  assign can_take = (state == EMPTY) || a_ready;
  assign credit   = (in_flight < MAX_C) || cpl_valid;
  assign pop      = !rst && fifo_not_empty && can_take && credit;
  assign fifo_rd_en = pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (pop)             state_nxt = HOLD;
      HOLD:  if (!pop && a_ready) state_nxt = EMPTY;
      default:                    state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    a_valid = (state == HOLD);
    a_id    = beat_q.id;
    a_addr  = beat_q.addr;
    a_len   = beat_q.len;
    a_size  = beat_q.size;
    a_burst = beat_q.burst;
  end

  // FIFO data is only trusted in the pop cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      beat_q <= '0;
    else if (pop) beat_q <= beat_in;
  end

  // A completion with nothing in flight is a protocol error and is ignored.
  assign cpl_eff = cpl_valid && (in_flight != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight <= '0;
    end else begin
      case ({pop, cpl_eff})
        2'b10:   in_flight <= in_flight + CNT_W'(1);
        2'b01:   in_flight <= in_flight - CNT_W'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) burst_err <= 1'b0;
    else     burst_err <= pop && (beat_in.burst == 2'b11);
  end

endmodule

// File: tb/tb_axi_addr_cdc_issuer.sv
// Bench for axi_addr_cdc_issuer: directed scenarios then random traffic, all
// checked against a queue-based FIFO plus a transaction-level port model.
module tb_axi_addr_cdc_issuer;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_not_empty = 1'b0;
  logic [48:0] fifo_r_data = '0;
  logic        fifo_rd_en;
  logic [7:0]  a_id;
  logic [31:0] a_addr;
  logic [3:0]  a_len;
  logic [2:0]  a_size;
  logic [1:0]  a_burst;
  logic        a_valid;
  logic        a_ready = 1'b0;
  logic        cpl_valid = 1'b0;
  logic [3:0]  in_flight;
  logic        burst_err;

  axi_addr_cdc_issuer #(.MAX_OUTSTANDING(MAXO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .fifo_not_empty(fifo_not_empty), .fifo_r_data(fifo_r_data),
    .fifo_rd_en(fifo_rd_en), .a_id(a_id), .a_addr(a_addr), .a_len(a_len), .a_size(a_size),
    .a_burst(a_burst), .a_valid(a_valid), .a_ready(a_ready), .cpl_valid(cpl_valid),
    .in_flight(in_flight), .burst_err(burst_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: FIFO contents, the beat presented on the port, outstanding count.
  logic [48:0] fifo_q[$];
  logic        m_valid = 1'b0;
  logic [48:0] m_beat  = '0;
  int          m_cnt   = 0;
  logic        m_err   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [48:0] mk(input logic [7:0] id, input logic [31:0] addr,
                                     input logic [3:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    return {id, addr, len, size, burst};
  endfunction

  function automatic logic [48:0] rnd_beat();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[48:0];
  endfunction

  // One clock: drive at posedge+1, check at negedge, advance the model for the coming edge.
  task automatic cycle(input logic rdy, input logic cpl);
    logic exp_pop;
    a_ready        = rdy;
    cpl_valid      = cpl;
    fifo_not_empty = (fifo_q.size() > 0);
    fifo_r_data    = fifo_not_empty ? fifo_q[0] : rnd_beat();
    @(negedge clk);
    exp_pop = !rst && fifo_not_empty && (!m_valid || rdy) && ((m_cnt < MAXO) || cpl);
    chk("rd_en", {63'd0, fifo_rd_en}, {63'd0, exp_pop});
    chk("a_valid", {63'd0, a_valid}, {63'd0, m_valid});
    if (m_valid) chk("a_fields", {15'd0, a_id, a_addr, a_len, a_size, a_burst}, {15'd0, m_beat});
    chk("in_flight", {60'd0, in_flight}, 64'(m_cnt));
    chk("burst_err", {63'd0, burst_err}, {63'd0, m_err});
    if (rst) begin
      m_valid = 1'b0; m_cnt = 0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (exp_pop) begin
        m_beat  = fifo_q.pop_front();
        m_valid = 1'b1;
        m_err   = (m_beat[1:0] == 2'b11);
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
      if (exp_pop && !(cpl && m_cnt > 0))      m_cnt++;
      else if (!exp_pop && cpl && m_cnt > 0)   m_cnt--;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset holds everything off even with data available
    fifo_q.push_back(mk(8'h11, 32'hA000_0000, 4'h0, 3'd3, 2'b01));
    #1;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    rst = 1'b0;
    cycle(1'b1, 1'b0);                       // pops on the first clock after release
    chk("t1_valid", {63'd0, a_valid}, 64'd1);
    chk("t1_addr", {32'd0, a_addr}, 64'hA000_0000);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b0);

    // 2: single beat held under backpressure
    fifo_q.push_back(mk(8'h3A, 32'h0000_1000, 4'h3, 3'd2, 2'b01));
    cycle(1'b0, 1'b0);
    repeat (5) cycle(1'b0, 1'b0);
    chk("t2_id", {56'd0, a_id}, 64'h3A);
    chk("t2_addr", {32'd0, a_addr}, 64'h1000);
    chk("t2_len_size_burst", {55'd0, a_len, a_size, a_burst}, {55'd0, 4'h3, 3'd2, 2'b01});
    cycle(1'b1, 1'b0);
    chk("t2_drop", {63'd0, a_valid}, 64'd0);
    chk("t2_inflight", {60'd0, in_flight}, 64'd1);
    cycle(1'b0, 1'b1);

    // 3: streaming up to the limit
    for (int i = 0; i < 5; i++) fifo_q.push_back(mk(8'(i), 32'(32'h2000 + i * 16), 4'h1, 3'd2, 2'b01));
    repeat (6) cycle(1'b1, 1'b0);
    chk("t3_inflight", {60'd0, in_flight}, 64'd4);
    chk("t3_fifo_left", 64'(fifo_q.size()), 64'd1);

    // 4: completion at the limit frees a same-cycle pop
    cycle(1'b1, 1'b1);
    chk("t4_inflight", {60'd0, in_flight}, 64'd4);
    chk("t4_popped", 64'(fifo_q.size()), 64'd0);
    fifo_q.push_back(mk(8'h44, 32'h4444_0000, 4'h0, 3'd0, 2'b00));
    cycle(1'b1, 1'b0);
    chk("t4_stall", 64'(fifo_q.size()), 64'd1);
    repeat (4) cycle(1'b1, 1'b1);
    repeat (3) cycle(1'b1, 1'b1);

    // 5: reserved burst type flagged, and completion at zero saturates
    fifo_q.push_back(mk(8'h55, 32'h5555_0000, 4'h2, 3'd1, 2'b11));
    cycle(1'b1, 1'b0);
    chk("t5_err", {63'd0, burst_err}, 64'd1);
    chk("t5_burst", {62'd0, a_burst}, 64'd3);
    cycle(1'b1, 1'b1);
    chk("t5_err_clr", {63'd0, burst_err}, 64'd0);
    cycle(1'b1, 1'b1);
    chk("t5_sat", {60'd0, in_flight}, 64'd0);

    // 6: asynchronous reset while holding a stalled beat
    fifo_q.push_back(mk(8'h66, 32'h6666_0000, 4'h7, 3'd2, 2'b10));
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", {63'd0, a_valid}, 64'd0);
    chk("t6_inflight", {60'd0, in_flight}, 64'd0);
    m_valid = 1'b0; m_cnt = 0; m_err = 1'b0;
    @(posedge clk); #1;
    fifo_q.push_back(mk(8'h67, 32'h6767_0000, 4'h1, 3'd2, 2'b01));
    cycle(1'b1, 1'b0);
    rst = 1'b0;
    cycle(1'b1, 1'b0);
    chk("t6_resume", {56'd0, a_id}, 64'h67);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if (fifo_q.size() < 4 && $urandom_range(0, 99) < 60) fifo_q.push_back(rnd_beat());
      cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 30);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
